// File: rtl/ptp_pkg.sv
// Shared constants and types for the Pico host <-> manchester_baby byte link.
package ptp_pkg;

  localparam int PTP_WORD_BYTES = 4;
  localparam int PTP_TX_BYTES   = 8;

  typedef logic [1:0] rx_lane_t;
  typedef logic [2:0] tx_lane_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } rx_state_e;

endpackage

// File: rtl/ptp_toggle_sync.sv
// Multi-flop synchroniser for one asynchronous host line, plus a registered
// XOR edge detector. level_o is the synchronised level; edge_o pulses for one
// cycle after every transition of that level. SYNC_STAGES must be at least 2.
module ptp_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  // Shift the raw line through the chain, then compare against its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign edge_o  = edge_q;

endmodule

// File: rtl/ptp_sync_link.sv
// Byte link between the Pico host pins and the manchester_baby core.
// RX: four host bytes (LSB lane first) are assembled into one 32-bit word that
// is offered to the core with a valid/ready handshake.
// Handshake: word_o is transferred on every rising edge where word_valid_o and
// word_ready_i are both high; word_o is stable while word_valid_o is high, and
// word_valid_o only falls on a transfer or on a host link reset.
// TX: a loaded {data, addr} pair is presented to the host one byte per host
// step. ADDR_W must be less than 32.
module ptp_sync_link
  import ptp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        host_byte_i,
  input  logic              host_rx_tgl_i,
  input  logic              host_tx_tgl_i,
  input  logic              host_rst_n_i,
  output logic [31:0]       word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  input  logic              tx_load_i,
  input  logic [ADDR_W-1:0] tx_addr_i,
  input  logic [31:0]       tx_data_i,
  output logic [7:0]        host_byte_o,
  output logic              tx_done_o,
  output logic              overrun_o
);

  logic rx_ev;
  logic tx_ev;
  logic link_rst_n;
  logic rst_edge_unused;

  ptp_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (host_rx_tgl_i),
    .level_o (),
    .edge_o  (rx_ev)
  );

  ptp_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tx_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (host_tx_tgl_i),
    .level_o (),
    .edge_o  (tx_ev)
  );

  // Host reset is a level: only the synchronised level is used.
  ptp_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_hrst_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (host_rst_n_i),
    .level_o (link_rst_n),
    .edge_o  (rst_edge_unused)
  );

  // ---------------------------------------------------------------- RX side
  rx_state_e   rx_state_q;
  rx_lane_t    idx_q;
  logic [31:0] word_q;
  logic        valid_q;
  logic        overrun_q;
  logic        handshake;

  assign handshake = valid_q & word_ready_i;

  // RX assembly FSM: fill lanes, hold the full word until the core takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= FILL;
      idx_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (!link_rst_n) begin
      // Partial lanes are abandoned; word_q keeps its last contents.
      rx_state_q <= FILL;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      case (rx_state_q)
        FILL: begin
          if (rx_ev) begin
            word_q[{idx_q, 3'b000} +: 8] <= host_byte_i;
            if (idx_q == rx_lane_t'(PTP_WORD_BYTES - 1)) begin
              idx_q      <= '0;
              valid_q    <= 1'b1;
              rx_state_q <= FULL;
            end else begin
              idx_q <= idx_q + rx_lane_t'(1);
            end
          end
        end
        FULL: begin
          if (handshake) begin
            valid_q    <= 1'b0;
            rx_state_q <= FILL;
            // A byte landing on the transfer cycle starts the next word.
            if (rx_ev) begin
              word_q[7:0] <= host_byte_i;
              idx_q       <= rx_lane_t'(1);
            end
          end else if (rx_ev) begin
            overrun_q <= 1'b1;
          end
        end
        default: rx_state_q <= FILL;
      endcase
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign overrun_o    = overrun_q;

  // ---------------------------------------------------------------- TX side
  logic [63:0] shadow_q, shadow_d;
  tx_lane_t    tidx_q, tidx_d;
  logic [7:0]  byte_q, byte_d;
  logic        done_q, done_d;

  // Next TX state: host reset beats load, load beats a step.
  always_comb begin
    shadow_d = shadow_q;
    tidx_d   = tidx_q;
    done_d   = 1'b0;
    if (!link_rst_n) begin
      tidx_d = '0;
    end else if (tx_load_i) begin
      shadow_d = {tx_data_i, {(32 - ADDR_W){1'b0}}, tx_addr_i};
      tidx_d   = '0;
    end else if (tx_ev) begin
      tidx_d = tidx_q + tx_lane_t'(1);
      done_d = (tidx_q == tx_lane_t'(PTP_TX_BYTES - 1));
    end
    byte_d = shadow_d[{tidx_d, 3'b000} +: 8];
  end

  // TX registers; the outgoing byte is registered from the next-state index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      tidx_q   <= '0;
      byte_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      tidx_q   <= tidx_d;
      byte_q   <= byte_d;
      done_q   <= done_d;
    end
  end

  assign host_byte_o = byte_q;
  assign tx_done_o   = done_q;

endmodule

// File: doc/ptp_sync_link.md
# ptp_sync_link

Clock-domain-safe byte link between the Pico host pins and the `manchester_baby` core. It assembles four host bytes into one 32-bit RAM word for the core with a valid/ready handshake. It also serialises the core's {address, data} pair back to the host one byte per host step. Host control lines are treated as asynchronous toggles and synchronised into `clk` before use.

## Interface

Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of every host-line synchroniser; minimum 2.
- `ADDR_W`, 5: width of the core RAM address.

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_byte_i`  in  8  host data byte.
- `host_rx_tgl_i`  in  1  host toggle; each transition (either edge) offers one byte.
- `host_tx_tgl_i`  in  1  host toggle; each transition advances the outgoing byte.
- `host_rst_n_i`  in  1  host-side link reset, asynchronous level, active low.
- `word_o`  out  32  assembled word to the core.
- `word_valid_o`  out  1  `word_o` holds a complete word.
- `word_ready_i`  in  1  core accepts `word_o`.
- `tx_load_i`  in  1  single-cycle pulse: capture `tx_addr_i` and `tx_data_i`.
- `tx_addr_i`  in  ADDR_W  core RAM address.
- `tx_data_i`  in  32  core RAM data.
- `host_byte_o`  out  8  current outgoing byte.
- `tx_done_o`  out  1  one-cycle pulse when the eighth byte has been stepped past.
- `overrun_o`  out  1  sticky flag: a byte arrived while a word was pending.

## Operation

Each host line passes through a `SYNC_STAGES` synchroniser. Toggle lines also get an edge detector, which produces a one-cycle event `rx_ev` / `tx_ev`.

RX state machine:
- FILL: on `rx_ev`, write `host_byte_i` into lane `idx` and increment `idx`. Byte order is LSB first: lane 0 is `word_o[7:0]`. The 4th byte sets `word_valid_o` and moves to FULL, with `idx` wrapping to 0.
- FULL: `word_o` is held stable. When `word_valid_o && word_ready_i`, clear `word_valid_o` and return to FILL.
- `rx_ev` in FULL without a handshake in the same cycle: the byte is dropped, `overrun_o` is set, and `word_o` is unchanged.
- `rx_ev` in FULL in the same cycle as a handshake: the byte is accepted as lane 0 of the next word, and `overrun_o` is not set.

TX path:
- `tx_load_i` captures a 64-bit shadow {`tx_data_i`, zero-extended `tx_addr_i`} and resets `tidx` to 0.
- Shadow byte order: bytes 0–3 are the address word, LSB first; bytes 4–7 are `tx_data_i`, LSB first.
- `host_byte_o` = shadow byte[`tidx`], registered.
- Each `tx_ev` increments `tidx`. On the `tx_ev` at `tidx`=7, `tidx` wraps to 0 and `tx_done_o` pulses.
- `tx_load_i` in the same cycle as `tx_ev`: the load wins and `tidx` becomes 0.

Host link reset (synchronised `host_rst_n_i` low):
- Clears `idx`, `word_valid_o`, `overrun_o` and `tidx`.
- `word_o` and the TX shadow are kept.
- Overrides any `rx_ev` / `tx_ev` / handshake in the same cycle.
- A reset mid-word discards any partial lanes.

## Timing

- `rst_n` low: every register is cleared asynchronously, so `word_o`=0, `word_valid_o`=0, `host_byte_o`=0, `tx_done_o`=0, `overrun_o`=0, and all synchroniser flops are 0.
- `rx_ev` and `tx_ev` assert `SYNC_STAGES`+1 rising edges after the first edge that samples the toggle.
- Byte capture and `word_valid_o` rise happen on the edge after `rx_ev`. With the default `SYNC_STAGES`, the 4th toggle gives `word_valid_o` high 4 cycles later.
- `host_byte_o` updates 1 cycle after `tx_ev` or `tx_load_i`.
- Host obligations: hold `host_byte_i` stable from before its toggle until `SYNC_STAGES`+3 cycles after it. Space toggles at least `SYNC_STAGES`+2 cycles apart.
- `word_valid_o` never drops without a handshake, except on host reset.

## Structure

- Package `ptp_pkg` holds:
  - `PTP_WORD_BYTES`=4 and `PTP_TX_BYTES`=8;
  - typedefs `rx_lane_t` (2 bits) and `tx_lane_t` (3 bits);
  - RX state enum {FILL, FULL}.
- Sub-module `ptp_toggle_sync` (synchroniser plus XOR edge detect, parameter `SYNC_STAGES`):
  - instantiated once for `host_rx_tgl_i` and once for `host_tx_tgl_i`;
  - the host reset line uses the same synchroniser with the level output taken and the edge output left unused.

## Test plan

- Reset: `rst_n` low with `host_rx_tgl_i` toggling → all outputs 0 and no `rx_ev` until release plus `SYNC_STAGES`+1.
- RX assembly: toggle in bytes 0xEF, 0xBE, 0xAD, 0xDE with `word_ready_i`=0 → `word_o`=0xDEADBEEF, `word_valid_o`=1 and held; then `word_ready_i`=1 for one cycle → valid falls.
- Overrun: with a word pending, toggle in byte 0x55 → `overrun_o`=1 and `word_o` unchanged. A byte edge coinciding with the handshake → accepted as lane 0, no overrun.
- TX: `tx_load_i` with addr=0x1F and data=0x12345678, then 8 `tx_ev` → bytes 1F, 00, 00, 00, 78, 56, 34, 12; `tx_done_o` pulses once; the next byte is 1F.
- Host reset: after 2 RX bytes and 3 TX steps, pulse `host_rst_n_i` → `idx`=0 and `tidx`=0; the next 4 RX bytes form a fresh word; `host_byte_o`=shadow byte 0.
- Load/step collision: `tx_load_i` and `tx_ev` in the same cycle → `tidx`=0 and new shadow byte 0 shown.
